// File: rtl/uart_regbank_pkg.sv
// Shared constants for the UART/IO register bank: per-channel register offsets,
// self-clearing CR bits, reset values and interrupt-block offsets.
package uart_regbank_pkg;

  typedef enum logic [2:0] {
    REG_CR  = 3'd0,
    REG_TTR = 3'd1,
    REG_SR  = 3'd2,
    REG_TDR = 3'd3,
    REG_RDR = 3'd4
  } ch_reg_e;

  localparam int CH_STRIDE   = 5;
  localparam int CR_RX_RESET = 1;
  localparam int CR_TX_RESET = 2;
  localparam int ERR_VALID   = 31;

  localparam logic [31:0] CR_RST_VAL       = 32'h0000_C000;
  localparam logic [31:0] TTR_RST_VAL      = 32'h0000_0004;
  localparam logic [31:0] GPIO_OUT_RST_VAL = 32'hFFFF_FFFF;

  localparam logic [1:0] IRQ_ISR = 2'd0;
  localparam logic [1:0] IRQ_IER = 2'd1;
  localparam logic [1:0] IRQ_ERR = 2'd2;

endpackage

// File: rtl/uart_regbank_if.sv
// Word-addressed local bus between the CPU bridge (master) and the register bank (slave).
interface uart_regbank_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  // Handshake: we/re are single-cycle strobes with no backpressure; every re is
  // answered by read_valid for exactly one cycle on the following clock, with
  // read_data holding its value until the next re.
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;

  modport master (output addr, we, re, write_data, input read_data, read_valid);
  modport slave  (input addr, we, re, write_data, output read_data, read_valid);
endinterface

// File: rtl/uart_regbank_ch.sv
// One UART channel's register slice: CR/TTR/TDR storage, CR self-clearing
// reset bits and the combinational access strobes.
module uart_regbank_ch
  import uart_regbank_pkg::*;
#(
  parameter int                ADDR_W = 22,
  parameter int                DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [DATA_W-1:0] i_write_data,
  output logic [DATA_W-1:0] o_cr,
  output logic [DATA_W-1:0] o_ttr,
  output logic [DATA_W-1:0] o_tdr,
  output logic              o_tx_write,
  output logic              o_rx_read,
  output logic              o_sr_read,
  output logic              o_hit,
  output ch_reg_e           o_reg
);

  localparam logic [DATA_W-1:0] SELF_CLR =
    (DATA_W'(1) << CR_RX_RESET) | (DATA_W'(1) << CR_TX_RESET);

  logic [ADDR_W:0]   w_diff;
  logic              w_hit;
  ch_reg_e           w_reg;
  logic [DATA_W-1:0] r_cr, r_ttr, r_tdr;

  // Extra borrow bit keeps the below-base test free of constant compares.
  assign w_diff = {1'b0, i_addr} - {1'b0, BASE};
  assign w_hit  = !w_diff[ADDR_W] && (w_diff[ADDR_W-1:0] < ADDR_W'(CH_STRIDE));
  assign w_reg  = ch_reg_e'(w_diff[2:0]);

  assign o_tx_write = i_we && w_hit && (w_reg == REG_TDR);
  assign o_sr_read  = i_re && w_hit && (w_reg == REG_SR);
  assign o_rx_read  = i_re && w_hit && (w_reg == REG_RDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cr  <= DATA_W'(CR_RST_VAL);
      r_ttr <= DATA_W'(TTR_RST_VAL);
      r_tdr <= '0;
    end else begin
      // A write in the same cycle overrides the self-clear of the reset bits.
      if (i_we && w_hit && (w_reg == REG_CR)) r_cr <= i_write_data;
      else                                    r_cr <= r_cr & ~SELF_CLR;
      if (i_we && w_hit && (w_reg == REG_TTR)) r_ttr <= i_write_data;
      if (o_tx_write)                          r_tdr <= i_write_data;
    end
  end

  assign o_cr  = r_cr;
  assign o_ttr = r_ttr;
  assign o_tdr = r_tdr;
  assign o_hit = w_hit;
  assign o_reg = w_reg;

endmodule

// File: rtl/uart_regbank.sv
// N-channel UART/IO register bank with registered reads, GPIO words and an
// optional interrupt/error block enabled by UART_REGBANK_IRQ_EN.
module uart_regbank
  import uart_regbank_pkg::*;
#(
  parameter int                NUM_CH    = 6,
  parameter int                NUM_GPIO  = 3,
  parameter int                ADDR_W    = 22,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] CH_BASE   = 'h0000,
  parameter logic [ADDR_W-1:0] GPIO_BASE = 'h0100,
  parameter logic [ADDR_W-1:0] IRQ_BASE  = 'h0200
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_regbank_if.slave              bus,
  output logic [NUM_CH*DATA_W-1:0]   cr,
  output logic [NUM_CH*DATA_W-1:0]   ttr,
  output logic [NUM_CH*DATA_W-1:0]   tdr,
  input  logic [NUM_CH*DATA_W-1:0]   sr,
  input  logic [NUM_CH*DATA_W-1:0]   rdr,
  output logic [NUM_CH-1:0]          tx_write,
  output logic [NUM_CH-1:0]          rx_read,
  output logic [NUM_CH-1:0]          sr_read,
  output logic [NUM_GPIO*DATA_W-1:0] gpio_o,
  input  logic [NUM_GPIO*DATA_W-1:0] gpio_i,
  input  logic [NUM_CH-1:0]          ch_event,
  output logic                       irq,
  output logic                       bus_err
);

  logic [NUM_CH-1:0]          w_ch_hit;
  ch_reg_e                    w_ch_reg [NUM_CH];
  logic [ADDR_W:0]            w_gdiff;
  logic                       w_g_hit;
  logic [ADDR_W-1:0]          w_goff;
  logic [NUM_GPIO*DATA_W-1:0] r_gpio_o;
  logic [DATA_W-1:0]          w_rdata, r_rdata;
  logic                       w_mapped, r_rvalid;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    uart_regbank_ch #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(CH_BASE + ADDR_W'(CH_STRIDE * c))
    ) u_ch (
      .clk(clk), .rst(rst), .i_addr(bus.addr), .i_we(bus.we), .i_re(bus.re),
      .i_write_data(bus.write_data),
      .o_cr(cr[c*DATA_W +: DATA_W]), .o_ttr(ttr[c*DATA_W +: DATA_W]),
      .o_tdr(tdr[c*DATA_W +: DATA_W]), .o_tx_write(tx_write[c]),
      .o_rx_read(rx_read[c]), .o_sr_read(sr_read[c]),
      .o_hit(w_ch_hit[c]), .o_reg(w_ch_reg[c])
    );
  end

  // GPIO window: outputs first, then the same number of input words.
  assign w_gdiff = {1'b0, bus.addr} - {1'b0, GPIO_BASE};
  assign w_g_hit = !w_gdiff[ADDR_W] && (w_gdiff[ADDR_W-1:0] < ADDR_W'(2 * NUM_GPIO));
  assign w_goff  = w_gdiff[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_o <= {NUM_GPIO{DATA_W'(GPIO_OUT_RST_VAL)}};
    end else begin
      for (int g = 0; g < NUM_GPIO; g++)
        if (bus.we && w_g_hit && (w_goff == ADDR_W'(g)))
          r_gpio_o[g*DATA_W +: DATA_W] <= bus.write_data;
    end
  end
  assign gpio_o = r_gpio_o;

`ifdef UART_REGBANK_IRQ_EN
  logic [ADDR_W:0]   w_idiff;
  logic              w_i_hit;
  logic [ADDR_W-1:0] w_ioff;
  logic [NUM_CH-1:0] r_isr, w_isr_clr;
  logic [DATA_W-1:0] r_ier, r_err, w_err_new;
  logic              r_irq, w_bad;

  assign w_idiff   = {1'b0, bus.addr} - {1'b0, IRQ_BASE};
  assign w_i_hit   = !w_idiff[ADDR_W] && (w_idiff[ADDR_W-1:0] < ADDR_W'(3));
  assign w_ioff    = w_idiff[ADDR_W-1:0];
  assign w_isr_clr = (bus.we && w_i_hit && (w_ioff == ADDR_W'(IRQ_ISR)))
                     ? bus.write_data[NUM_CH-1:0] : '0;
  assign w_bad     = (bus.we || bus.re) && !w_mapped;

  always_comb begin
    w_err_new                = '0;
    w_err_new[ADDR_W-1:0]    = bus.addr;
    w_err_new[ERR_VALID]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_isr <= '0;
      r_ier <= '0;
      r_err <= '0;
      r_irq <= 1'b0;
    end else begin
      // New events are ORed in after the clear so a coincident event survives.
      r_isr <= (r_isr & ~w_isr_clr) | ch_event;
      if (bus.we && w_i_hit && (w_ioff == ADDR_W'(IRQ_IER))) r_ier <= bus.write_data;
      if (bus.we && w_i_hit && (w_ioff == ADDR_W'(IRQ_ERR))) r_err <= '0;
      else if (w_bad && !r_err[ERR_VALID])                   r_err <= w_err_new;
      r_irq <= |(r_isr & r_ier[NUM_CH-1:0]);
    end
  end

  assign irq     = r_irq;
  assign bus_err = r_err[ERR_VALID];
`else
  logic w_unused_irq;
  assign w_unused_irq = ^ch_event ^ w_mapped;
  assign irq          = 1'b0;
  assign bus_err      = 1'b0;
`endif

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_hit[c]) begin
        w_mapped = 1'b1;
        case (w_ch_reg[c])
          REG_CR:  w_rdata = cr[c*DATA_W +: DATA_W];
          REG_TTR: w_rdata = ttr[c*DATA_W +: DATA_W];
          REG_SR:  w_rdata = sr[c*DATA_W +: DATA_W];
          REG_TDR: w_rdata = tdr[c*DATA_W +: DATA_W];
          REG_RDR: w_rdata = rdr[c*DATA_W +: DATA_W];
          default: ;
        endcase
      end
    end
    if (w_g_hit) begin
      w_mapped = 1'b1;
      for (int g = 0; g < NUM_GPIO; g++) begin
        if (w_goff == ADDR_W'(g))            w_rdata = r_gpio_o[g*DATA_W +: DATA_W];
        if (w_goff == ADDR_W'(NUM_GPIO + g)) w_rdata = gpio_i[g*DATA_W +: DATA_W];
      end
    end
`ifdef UART_REGBANK_IRQ_EN
    if (w_i_hit) begin
      w_mapped = 1'b1;
      case (w_ioff[1:0])
        IRQ_ISR: w_rdata = DATA_W'(r_isr);
        IRQ_IER: w_rdata = r_ier;
        IRQ_ERR: w_rdata = r_err;
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.re;
      if (bus.re) r_rdata <= w_rdata;
    end
  end

  assign bus.read_data  = r_rdata;
  assign bus.read_valid = r_rvalid;

endmodule

// File: doc/uart_regbank.md
# uart_regbank

Parametrised CPU-facing register bank for the UART/IO subsystem: decodes a word-addressed local bus into per-channel UART control/status registers, general-purpose output/input words and an interrupt block. It replaces the fixed six-channel decoder with a generic N-channel bank that adds registered read data with a valid flag, sticky interrupt aggregation and unmapped-access error capture. It sits between the CPU bus bridge and the UART channel instances.

## Interface
- NUM_CH, 6, UART channels (1..16)
- NUM_GPIO, 3, GPIO output words and input words (1..8)
- ADDR_W, 22, word-address width
- DATA_W, 32, register width
- CH_BASE, 22'h0000, address of channel 0 CR; channel c register k at CH_BASE + 5*c + k
- GPIO_BASE, 22'h0100, outputs at GPIO_BASE+g, inputs at GPIO_BASE+NUM_GPIO+g
- IRQ_BASE, 22'h0200, ISR at +0, IER at +1, ERR at +2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_W  word address
- we  in  1  write strobe, one cycle per write
- re  in  1  read strobe, one cycle per read
- write_data  in  DATA_W  write data
- read_data  out  DATA_W  registered read data
- read_valid  out  1  high one cycle after an accepted re
- cr, ttr, tdr  out  NUM_CH*DATA_W  per-channel config, timeout, transmit data (channel c at slice c)
- sr, rdr  in  NUM_CH*DATA_W  per-channel status, receive data
- tx_write, rx_read, sr_read  out  NUM_CH  single-cycle access strobes
- gpio_o  out  NUM_GPIO*DATA_W  output words
- gpio_i  in  NUM_GPIO*DATA_W  input words
- ch_event  in  NUM_CH  per-channel interrupt event pulses
- irq  out  1  aggregated interrupt
- bus_err  out  1  sticky unmapped-access flag

## Operation
- Register offsets per channel: 0 CR (RW), 1 TTR (RW), 2 SR (RO), 3 TDR (RW), 4 RDR (RO).
- Reset values: cr 32'h0000C000, ttr 32'h00000004, tdr 0, gpio_o all ones, ISR/IER 0, ERR 0, read_data 0, read_valid 0, irq 0, bus_err 0.
- Strobes combinational from addr/we/re: tx_write[c]=we at TDR c; sr_read[c]=re at SR c; rx_read[c]=re at RDR c.
- CR self-clearing bits CR_RX_RESET and CR_TX_RESET: cleared the cycle after being set; a write setting the bit in that same cycle wins (bit stays 1 one more cycle).
- Writes to RO addresses ignored, no error. Writes/reads outside all mapped ranges: ignored / return 0, set ERR[31]=1 and ERR[ADDR_W-1:0]=addr (first error only until cleared); bus_err=ERR[31].
- ISR bit c set by ch_event[c]; cleared by writing 1 to ISR bit c; simultaneous set and clear -> set wins. IER plain RW. Writing any value to ERR clears it.
- irq registered: irq <= |(ISR & IER).
- re and we in the same cycle to the same address: read returns pre-write value.

## Timing
- Writes take effect at the clk edge where we=1; outputs visible next cycle.
- Read latency 1: read_data/read_valid valid the cycle after re; read_data holds until next re.
- ch_event to irq: 2 cycles (ISR set, then irq register).
- rst mid-operation: all state to reset values on that edge; strobes still follow inputs combinationally.

## Configuration
- UART_REGBANK_IRQ_EN: when defined, ISR/IER/ERR, irq and bus_err are implemented as above. When undefined, irq and bus_err are tied 0, IRQ_BASE range is unmapped (reads 0), ch_event is ignored and no error capture exists.

## Structure
- Package uart_regbank_pkg: register offsets (CR/TTR/SR/TDR/RDR = 0..4), CH_STRIDE=5, CR_RX_RESET=1, CR_TX_RESET=2, reset constants for CR, TTR, GPIO out, ERR_VALID bit 31.
- One sub-module uart_regbank_ch: per-channel CR/TTR/TDR storage, self-clear logic and strobe decode, instantiated NUM_CH times via generate.

## Test plan
- After rst: read CR2 -> 32'h0000C000 with read_valid one cycle after re; read TTR5 -> 4; gpio_o = all ones.
- Write CR0=32'h0000C006 -> cr0 bits 1,2 high one cycle, then cr0=32'h0000C000; rewrite same cycle keeps bit high.
- Write TDR3=32'h55 -> tx_write[3] high exactly that cycle, tdr3=32'h55 next cycle; read RDR1 -> rx_read[1] pulse, read_data=rdr1.
- IER=32'h4, pulse ch_event[2] -> irq high 2 cycles later; write ISR=32'h4 coincident with new ch_event[2] -> ISR bit stays set.
- Read addr 22'h3FFF -> read_data 0, bus_err=1, ERR=32'h80003FFF; second bad access leaves ERR unchanged; write ERR -> cleared.
- Without UART_REGBANK_IRQ_EN: ch_event pulses -> irq stays 0; read IRQ_BASE -> 0.
